// File: rtl/uc_write_buffer_pkg.sv
// Shared types for the uncached store buffer: entry layout, drain FSM states, merge helpers.
// Optional store merging is built when UC_WBUF_MERGE_EN is defined.
package uc_write_buffer_pkg;

  localparam int unsigned UC_WBUF_DEPTH = 4;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned WenW  = 4;
  localparam int unsigned SizeW = 2;

  typedef enum logic [2:0] {
    StIdle  = 3'b001,
    StIssue = 3'b010,
    StWait  = 3'b100
  } drain_state_e;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
    logic [WenW-1:0]  wen;
    logic [SizeW-1:0] size;
  } wbuf_entry_t;

  // Smallest AXI size covering a merged enable mask; anything irregular becomes a word.
  function automatic logic [SizeW-1:0] wen_to_size(input logic [WenW-1:0] wen);
    logic [SizeW-1:0] sz;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'b00;
      4'b0011, 4'b1100:                   sz = 2'b01;
      default:                            sz = 2'b10;
    endcase
    return sz;
  endfunction

  function automatic wbuf_entry_t merge_entry(input wbuf_entry_t old_e, input wbuf_entry_t new_e);
    wbuf_entry_t r;
    r = old_e;
    for (int b = 0; b < WenW; b++) begin
      if (new_e.wen[b]) r.data[8*b +: 8] = new_e.data[8*b +: 8];
    end
    r.wen  = old_e.wen | new_e.wen;
    r.size = wen_to_size(r.wen);
    return r;
  endfunction

endpackage

// File: rtl/uc_write_buffer_if.sv
// Enqueue and drain-side bus of the uncached store buffer.
// master = dcache / dcache_axi side, slave = the buffer.
interface uc_write_buffer_if;
  import uc_write_buffer_pkg::*;

  logic             enq_valid;
  logic             enq_ready;
  logic [AddrW-1:0] enq_addr;
  logic [DataW-1:0] enq_data;
  logic [WenW-1:0]  enq_wen;
  logic [SizeW-1:0] enq_size;

  logic             axi_idle_i;
  logic             axi_wend_i;
  logic             uc_wreq_o;
  logic [AddrW-1:0] uc_waddr_o;
  logic [DataW-1:0] uc_wdata_o;
  logic [WenW-1:0]  uc_wen_o;
  logic [SizeW-1:0] uc_wsize_o;

  modport master (
    output enq_valid, enq_addr, enq_data, enq_wen, enq_size, axi_idle_i, axi_wend_i,
    input  enq_ready, uc_wreq_o, uc_waddr_o, uc_wdata_o, uc_wen_o, uc_wsize_o
  );

  modport slave (
    input  enq_valid, enq_addr, enq_data, enq_wen, enq_size, axi_idle_i, axi_wend_i,
    output enq_ready, uc_wreq_o, uc_waddr_o, uc_wdata_o, uc_wen_o, uc_wsize_o
  );

endinterface

// File: rtl/uc_wbuf_fifo.sv
// Circular store FIFO with per-entry word-address hazard compare.
// Tail merging is compiled in when UC_WBUF_MERGE_EN is defined.
module uc_wbuf_fifo
  import uc_write_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = UC_WBUF_DEPTH,
  localparam int unsigned PtrW  = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              push,
  input  wbuf_entry_t       push_entry,
  input  logic              pop,
`ifdef UC_WBUF_MERGE_EN
  input  logic              head_locked,
`endif
  input  logic [AddrW-1:2]  chk_word,
  output wbuf_entry_t       head_entry,
  output logic [PtrW:0]     count,
  output logic              full,
  output logic              hazard,
  output logic              merge_hit
);

  wbuf_entry_t         mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q, tail_ptr, offs;
  logic [PtrW:0]       count_q;
  logic                alloc;

  assign tail_ptr = wr_ptr_q - 1'b1;

`ifdef UC_WBUF_MERGE_EN
  // A lone entry that is already being issued must not change under dcache_axi.
  assign merge_hit = (count_q != '0) &&
                     (mem_q[tail_ptr].addr[AddrW-1:2] == push_entry.addr[AddrW-1:2]) &&
                     !((count_q == (PtrW+1)'(1)) && head_locked);
`else
  assign merge_hit = 1'b0;
`endif

  assign alloc = push & ~merge_hit;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (alloc) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
`ifdef UC_WBUF_MERGE_EN
      if (push && merge_hit) mem_q[tail_ptr] <= merge_entry(mem_q[tail_ptr], push_entry);
`endif
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({alloc, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    hazard = 1'b0;
    offs   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PtrW'(i) - rd_ptr_q;
      if (({1'b0, offs} < count_q) && (mem_q[i].addr[AddrW-1:2] == chk_word)) hazard = 1'b1;
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign full       = (count_q == (PtrW+1)'(DEPTH));

endmodule

// File: rtl/uc_write_buffer.sv
// Uncached store buffer: queues stores and drains them in order as single-beat uc_wreq pulses.
// Define UC_WBUF_MERGE_EN to merge same-word stores into the queued tail entry.
module uc_write_buffer
  import uc_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = UC_WBUF_DEPTH
) (
  input  logic                   aclk,
  input  logic                   areset,
  uc_write_buffer_if.slave       bus,
  input  logic [AddrW-1:0]       rd_chk_addr,
  output logic                   rd_hazard,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  drain_state_e state_q;
  logic         uc_wreq_q;
  wbuf_entry_t  out_q;
  wbuf_entry_t  head_entry, push_entry;
  logic         full, merge_hit, push, pop;
  logic         unused_chk_lsb;

  assign push_entry = '{addr: bus.enq_addr, data: bus.enq_data,
                        wen: bus.enq_wen, size: bus.enq_size};

  assign bus.enq_ready = ~full | merge_hit;
  assign push          = bus.enq_valid & bus.enq_ready;
  assign pop           = (state_q == StWait) & bus.axi_wend_i;

`ifdef UC_WBUF_MERGE_EN
  logic head_locked;
  // Head counts as in flight from the cycle it may be latched for issue.
  assign head_locked = (state_q != StIdle) | bus.axi_idle_i;
`endif

  uc_wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk        (aclk),
    .areset      (areset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
`ifdef UC_WBUF_MERGE_EN
    .head_locked (head_locked),
`endif
    .chk_word    (rd_chk_addr[AddrW-1:2]),
    .head_entry  (head_entry),
    .count       (count),
    .full        (full),
    .hazard      (rd_hazard),
    .merge_hit   (merge_hit)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= StIdle;
      uc_wreq_q <= 1'b0;
      out_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if ((count != '0) && bus.axi_idle_i) begin
            state_q   <= StIssue;
            uc_wreq_q <= 1'b1;
            out_q     <= head_entry;
          end
        end
        StIssue: begin
          uc_wreq_q <= 1'b0;
          state_q   <= StWait;
        end
        StWait: begin
          if (bus.axi_wend_i) state_q <= StIdle;
        end
        default: begin
          state_q   <= StIdle;
          uc_wreq_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.uc_wreq_o  = uc_wreq_q;
  assign bus.uc_waddr_o = out_q.addr;
  assign bus.uc_wdata_o = out_q.data;
  assign bus.uc_wen_o   = out_q.wen;
  assign bus.uc_wsize_o = out_q.size;

  assign empty          = (count == '0) && (state_q == StIdle);
  assign unused_chk_lsb = ^rd_chk_addr[1:0];

endmodule
